// File: rtl/axi_lite_master.sv
// ============================================================================
// Module   : axi_lite_master
// Purpose  : Single-outstanding AXI4-Lite initiator; turns one local command
//            into one write or read transaction and returns one response.
//            Optional watchdog abort enabled by defining AXI_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int REG_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [REG_WIDTH-1:0]  cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [REG_WIDTH-1:0]  WDATA,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [REG_WIDTH-1:0]  RDATA
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [2:0]            r_state;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [REG_WIDTH-1:0]  r_wdata;
    logic [REG_WIDTH-1:0]  r_rsp_rdata;

    logic w_aw_done;
    logic w_w_done;
    logic w_stay;
    logic w_timeout;
    logic w_abort;
    logic w_in_write;

    // A channel counts as done once its VALID has been dropped or is handshaking now
    assign w_aw_done  = !r_awvalid || AWREADY;
    assign w_w_done   = !r_wvalid  || WREADY;
    assign w_in_write = (r_state == S_WR_REQ) || (r_state == S_WR_RESP);

    assign w_stay = ((r_state == S_WR_REQ)  && !(w_aw_done && w_w_done)) ||
                    ((r_state == S_WR_RESP) && !BVALID)                  ||
                    ((r_state == S_RD_REQ)  && !ARREADY)                 ||
                    ((r_state == S_RD_DATA) && !RVALID);
    assign w_abort = w_stay && w_timeout;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_rsp_err;

    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = r_rsp_err;

    // Counter runs only while waiting in one state; any state change clears it
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_stay && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_abort) begin
                r_rsp_err <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                r_rsp_err <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
        end else if (w_abort) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= w_in_write;
            r_rsp_rdata <= '0;
            r_state     <= S_RSP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_done && w_w_done) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= S_WR_RESP;
                    end else begin
                        if (AWREADY) r_awvalid <= 1'b0;
                        if (WREADY)  r_wvalid  <= 1'b0;
                    end
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= RDATA;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign AWVALID   = r_awvalid;
    assign AWADDR    = r_awaddr;
    assign WVALID    = r_wvalid;
    assign WDATA     = r_wdata;
    assign BREADY    = r_bready;
    assign ARVALID   = r_arvalid;
    assign ARADDR    = r_araddr;
    assign RREADY    = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
// Module   : tb_axi_lite_master
// Purpose  : Directed self-checking bench for axi_lite_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 256;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [15:0] WDATA;
    logic        BVALID;
    logic        BREADY;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic [15:0] RDATA;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_master #(
        .ADDR_WIDTH     (4),
        .REG_WIDTH      (16),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) u_dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    int cnt_a;
    int cnt_b;
    int cnt_c;
    logic [15:0] held;

    initial begin
        ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;

        // Reset state
        #12;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_valids", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
        check_eq("rst_rsp", {15'd0, rsp_valid, rsp_write, rsp_err, rsp_rdata}, 32'd0);
        ARESETn = 1'b1;
        tick();

        // Write, slave always ready
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 16'h1234;
        tick();
        cmd_valid = 1'b0;
        check_eq("wr_c1_valids", {30'd0, AWVALID, WVALID}, 32'd3);
        check_eq("wr_c1_awaddr", 32'(AWADDR), 32'h2);
        check_eq("wr_c1_wdata", 32'(WDATA), 32'h1234);
        check_eq("wr_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check_eq("wr_c2_state", {29'd0, AWVALID, WVALID, BREADY, rsp_valid}, 32'b0010);
        tick();
        check_eq("wr_c3_rsp", {28'd0, rsp_valid, rsp_write, rsp_err, BREADY}, 32'b1100);
        check_eq("wr_c3_rdata", 32'(rsp_rdata), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("wr_done_idle", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;

        // Skewed write channels: W handshake five cycles after AW
        AWREADY = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 16'hBEEF;
        tick();
        cmd_valid = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 1; c <= 10; c++) begin
            if (AWVALID) cnt_a++;
            if (WVALID) cnt_b++;
            WREADY = (c == 6);
            tick();
        end
        WREADY = 1'b0; AWREADY = 1'b0;
        check_eq("skew_awvalid_cycles", 32'(cnt_a), 32'd1);
        check_eq("skew_wvalid_cycles", 32'(cnt_b), 32'd6);
        check_eq("skew_wr_resp_bready", {30'd0, BREADY, rsp_valid}, 32'b10);
        BVALID = 1'b1;
        cnt_c = 0;
        for (int c = 0; c < 5; c++) begin
            if (BREADY) cnt_c++;
            tick();
        end
        BVALID = 1'b0;
        check_eq("skew_b_handshakes", 32'(cnt_c), 32'd1);
        check_eq("skew_rsp", {29'd0, rsp_valid, rsp_write, rsp_err}, 32'b110);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cnt_c = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid) cnt_c++;
            tick();
        end
        check_eq("skew_single_rsp", 32'(cnt_c), 32'd0);

        // Read with ARREADY after 3 cycles and RVALID 2 cycles later
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h1;
        tick();
        cmd_valid = 1'b0;
        check_eq("rd_araddr", 32'(ARADDR), 32'h1);
        cnt_a = 0;
        for (int c = 1; c <= 4; c++) begin
            if (ARVALID) cnt_a++;
            ARREADY = (c == 4);
            tick();
        end
        ARREADY = 1'b0;
        check_eq("rd_arvalid_cycles", 32'(cnt_a), 32'd4);
        check_eq("rd_c5", {30'd0, ARVALID, RREADY}, 32'b01);
        tick();
        RVALID = 1'b1; RDATA = 16'h00FF;
        tick();
        RVALID = 1'b0; RDATA = 16'hDEAD;
        check_eq("rd_rsp_flags", {28'd0, rsp_valid, rsp_write, rsp_err, RREADY}, 32'b1000);
        check_eq("rd_rsp_rdata", 32'(rsp_rdata), 32'h00FF);

        // Response backpressure with a new command waiting
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h7; cmd_wdata = 16'hA5A5;
        held = rsp_rdata;
        cnt_a = 0;
        for (int c = 0; c < 10; c++) begin
            RDATA = 16'(c * 16'h1111);
            if (!rsp_valid || rsp_rdata !== held || cmd_ready || AWVALID) cnt_a++;
            tick();
        end
        check_eq("bp_stable_cycles_bad", 32'(cnt_a), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("bp_after_hs", {29'd0, cmd_ready, rsp_valid, AWVALID}, 32'b100);
        AWREADY = 1'b1; WREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_eq("bp_next_accept", {30'd0, AWVALID, WVALID}, 32'b11);
        check_eq("bp_next_awaddr", 32'(AWADDR), 32'h7);
        tick();
        AWREADY = 1'b0; WREADY = 1'b0;
        check_eq("rst_pre_wr_resp", 32'(BREADY), 32'd1);

        // Reset while in WR_RESP: asynchronous clear, no response afterwards
        #2;
        ARESETn = 1'b0;
        #1;
        check_eq("arst_outputs", {22'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY,
                                  rsp_valid, rsp_write, rsp_err, cmd_ready, 1'b0}, 32'b10);
        check_eq("arst_addr_data", {12'd0, AWADDR, WDATA}, 32'd0);
        BVALID = 1'b1;
        #1;
        ARESETn = 1'b1;
        cnt_a = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid || BREADY || !cmd_ready) cnt_a++;
        end
        BVALID = 1'b0;
        check_eq("arst_no_rsp", 32'(cnt_a), 32'd0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog: ARREADY held low
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3;
        tick();
        cmd_valid = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 20 && !rsp_valid; c++) begin
            if (ARVALID) cnt_a++;
            tick();
        end
        check_eq("to_arvalid_cycles", 32'(cnt_a), 32'd8);
        check_eq("to_rsp", {28'd0, rsp_valid, rsp_write, rsp_err, ARVALID}, 32'b1010);
        check_eq("to_rdata", 32'(rsp_rdata), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 16'h0042;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("to_next_write", {29'd0, rsp_valid, rsp_write, rsp_err}, 32'b110);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single register commands from a local requester (sequencer, CPU shim or testbench driver) into AXI4-Lite write and read transactions. It is the counterpart of `axi_lite_slave` and drives its channels directly, for example to program prescale, period and duty registers in `axi_pwm`. It runs one transaction at a time and returns a single response per command.

## Interface
- `ADDR_WIDTH`, default 4: AXI address width; matches the slave's `ADDR_WIDTH`.
- `REG_WIDTH`, default 16: data width of WDATA, RDATA and the command/response data.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles. Used only when `AXI_MASTER_TIMEOUT_EN` is defined; must be ≥ 2.

Ports:
- `ACLK`  in  1  clock; all logic is on the rising edge.
- `ARESETn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  register address.
- `cmd_wdata`  in  REG_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_write`  out  1  echoes `cmd_write` of the completed command.
- `rsp_rdata`  out  REG_WIDTH  read data; 0 for writes.
- `rsp_err`  out  1  timeout flag; constant 0 when the watchdog is compiled out.
- `AWVALID`  out  1  write address valid.
- `AWREADY`  in  1  write address ready.
- `AWADDR`  out  ADDR_WIDTH  write address.
- `WVALID`  out  1  write data valid.
- `WREADY`  in  1  write data ready.
- `WDATA`  out  REG_WIDTH  write data.
- `BVALID`  in  1  write response valid.
- `BREADY`  out  1  write response ready.
- `ARVALID`  out  1  read address valid.
- `ARREADY`  in  1  read address ready.
- `ARADDR`  out  ADDR_WIDTH  read address.
- `RVALID`  in  1  read data valid.
- `RREADY`  out  1  read data ready.
- `RDATA`  in  REG_WIDTH  read data.

## Operation
- The FSM has six states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- `cmd_ready` = (state == IDLE), combinational. It is therefore 1 while in reset.
- **IDLE:**
  - On command accept, latch address and data.
  - Write command: go to WR_REQ and set AWVALID = WVALID = 1.
  - Read command: go to RD_REQ and set ARVALID = 1.
- **WR_REQ:**
  - The AW and W channels complete independently.
  - Each VALID clears on the edge where its handshake occurs, and never reasserts for the same command.
  - Once both handshakes are done (possibly on the same edge), go to WR_RESP.
- **WR_RESP:** BREADY = 1. On BVALID, go to RSP with `rsp_write` = 1 and `rsp_rdata` = 0.
- **RD_REQ:** ARVALID is held until ARREADY is seen, then go to RD_DATA.
- **RD_DATA:** RREADY = 1. On RVALID, capture RDATA into `rsp_rdata` and go to RSP.
- **RSP:**
  - `rsp_valid` = 1, and all response fields are held stable.
  - When `rsp_ready` is seen, return to IDLE.
- AWADDR, WDATA and ARADDR come from the latched command and stay stable while their VALID is high.
- A BVALID or RVALID arriving outside WR_RESP or RD_DATA is ignored, because the matching READY is 0.
- Reset values:
  - All VALID/READY outputs, `rsp_*`, addresses and data are 0.
  - The state is IDLE.
- An asserted reset aborts any transaction immediately; no response is produced for it.

## Timing
- The command is accepted on edge 0. Request VALIDs are high from cycle 1, registered.
- Best case for a write, with AWREADY, WREADY and BVALID all high: `rsp_valid` is high from cycle 3.
- Best case for a read, with ARREADY and RVALID high: `rsp_valid` is high from cycle 3.
- One command is in flight at a time. The earliest next accept is the cycle after the `rsp_valid`/`rsp_ready` handshake.
- All outputs are registered except `cmd_ready`.

## Configuration
- `AXI_MASTER_TIMEOUT_EN` defined:
  - A counter clears on every state entry and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - If the counter reaches TIMEOUT_CYCLES − 1 without the awaited handshake, the FSM does three things on the next edge:
    - deasserts all VALID and READY outputs;
    - moves to RSP with `rsp_err` = 1 and `rsp_rdata` = 0;
    - keeps `rsp_write` set from the command.
  - This is a deliberate protocol abort intended for debug recovery.
- `AXI_MASTER_TIMEOUT_EN` undefined:
  - No counter is built, and `rsp_err` = 0.
  - The FSM waits indefinitely for each handshake.

## Test plan
- **Write, slave always ready:** cmd write addr 0x2, data 0x1234 → AWADDR = 0x2 and WDATA = 0x1234 with VALIDs in cycle 1; `rsp_valid` in cycle 3 with `rsp_write` = 1 and `rsp_err` = 0.
- **Skewed write channels:** WREADY delayed 5 cycles after AWREADY → AWVALID drops after 1 cycle; WVALID is held 6 cycles; exactly one BREADY handshake; one response.
- **Read:** cmd read addr 0x1; slave returns RDATA 0x00FF after ARREADY is delayed 3 cycles and RVALID 2 more → `rsp_rdata` = 0x00FF with `rsp_write` = 0.
- **Response backpressure:** `rsp_ready` low for 10 cycles → `rsp_valid` and `rsp_rdata` stay stable, `cmd_ready` stays 0, and a new command is accepted the cycle after the handshake.
- **Timeout (macro defined, TIMEOUT_CYCLES = 8):** ARREADY tied low → ARVALID drops after 8 cycles; response has `rsp_err` = 1 and `rsp_rdata` = 0; a following write completes normally.
- **Reset mid-transaction:** ARESETn asserted while in WR_RESP → all outputs 0 asynchronously; no response after release; `cmd_ready` = 1.
